// File: rtl/window_range_tracker.sv
// rtl/window_range_tracker.sv - per-window max/min/new-max tracker over valid/ready streams
// Optional out_spread port and logic enabled by defining RANGE_TRACKER_SPREAD_EN.
module window_range_tracker #(
   parameter int WIDTH  = 3,
   parameter int WINDOW = 4,
   parameter int CW     = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_min,
   output logic [CW-1:0]    out_newmax,
`ifdef RANGE_TRACKER_SPREAD_EN
   output logic [WIDTH-1:0] out_spread,
`endif
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [CW-1:0] C_WINDOW = CW'(WINDOW);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_max;
   logic [WIDTH-1:0] r_min;
   logic [CW-1:0]    r_newmax;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_max_next;
   logic [WIDTH-1:0] w_min_next;
   logic [CW-1:0]    w_newmax_next;
   logic [CW-1:0]    w_cnt_next;
   logic [WIDTH-1:0] r_out_max;
   logic [WIDTH-1:0] r_out_min;
   logic [CW-1:0]    r_out_newmax;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_take;
   logic             w_load_out;

   // in_ready is gated by rst so it reads 0 throughout reset and 1 right after.
   assign w_in_ready = (r_state != ST_HOLD) && !rst;
   assign w_accept   = in_valid && w_in_ready;
   assign w_take     = (r_state == ST_HOLD) && out_ready;
   assign w_load_out = (r_state != ST_HOLD) && (w_state_next == ST_HOLD);

   always_comb begin
      w_state_next  = r_state;
      w_max_next    = r_max;
      w_min_next    = r_min;
      w_newmax_next = r_newmax;
      w_cnt_next    = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_max_next    = in_data;
               w_min_next    = in_data;
               w_newmax_next = '0;
               w_cnt_next    = CW'(1);
               w_state_next  = (WINDOW == 1) ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (w_accept) begin
               w_cnt_next = r_cnt + CW'(1);
               if (in_data > r_max) begin
                  w_max_next    = in_data;
                  w_newmax_next = r_newmax + CW'(1);
               end
               if (in_data < r_min) begin
                  w_min_next = in_data;
               end
               if (w_cnt_next == C_WINDOW) begin
                  w_state_next = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (w_take) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Result registers load only on HOLD entry so they stay put between windows.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_max        <= '0;
         r_min        <= '0;
         r_newmax     <= '0;
         r_cnt        <= '0;
         r_out_max    <= '0;
         r_out_min    <= '0;
         r_out_newmax <= '0;
      end else begin
         r_state  <= w_state_next;
         r_max    <= w_max_next;
         r_min    <= w_min_next;
         r_newmax <= w_newmax_next;
         r_cnt    <= w_cnt_next;
         if (w_load_out) begin
            r_out_max    <= w_max_next;
            r_out_min    <= w_min_next;
            r_out_newmax <= w_newmax_next;
         end
      end
   end

`ifdef RANGE_TRACKER_SPREAD_EN
   logic [WIDTH-1:0] r_out_spread;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_spread <= '0;
      end else if (w_load_out) begin
         r_out_spread <= w_max_next - w_min_next;
      end
   end

   assign out_spread = r_out_spread;
`endif

   assign in_ready   = w_in_ready;
   assign out_valid  = (r_state == ST_HOLD);
   assign out_max    = r_out_max;
   assign out_min    = r_out_min;
   assign out_newmax = r_out_newmax;

endmodule

// File: tb/tb_window_range_tracker.sv
// tb/tb_window_range_tracker.sv - self-checking bench for window_range_tracker
// Exercises out_spread as well when RANGE_TRACKER_SPREAD_EN is defined.
module tb_window_range_tracker;

   localparam int WIDTH  = 3;
   localparam int WINDOW = 4;
   localparam int CW     = $clog2(WINDOW + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
   logic [CW-1:0]    out_newmax;
`ifdef RANGE_TRACKER_SPREAD_EN
   logic [WIDTH-1:0] out_spread;
`endif

   int errors = 0;
   int checks = 0;

   int stim [0:7];
   int exp_max;
   int exp_min;
   int exp_nm;

   window_range_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_max    (out_max),
      .out_min    (out_min),
      .out_newmax (out_newmax),
`ifdef RANGE_TRACKER_SPREAD_EN
      .out_spread (out_spread),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   // Reference: max/min over the window; newmax counts samples above every earlier sample.
   task automatic ref_model(input int n);
      int pm;
      exp_max = stim[0];
      exp_min = stim[0];
      exp_nm  = 0;
      for (int i = 0; i < n; i++) begin
         if (stim[i] > exp_max) exp_max = stim[i];
         if (stim[i] < exp_min) exp_min = stim[i];
      end
      for (int i = 1; i < n; i++) begin
         pm = 0;
         for (int j = 0; j < i; j++) if (stim[j] > pm) pm = stim[j];
         if (stim[i] > pm) exp_nm++;
      end
   endtask

   // Drives n samples from stim[] with gap idle cycles before each; returns at the
   // falling edge right after the last accept.
   task automatic send_samples(input int n, input int gap);
      int guard;
      for (int i = 0; i < n; i++) begin
         repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = WIDTH'(stim[i]);
         guard    = 0;
         while (in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 40) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1 for sample %0d", in_ready, i);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      checks++; if (out_max !== 3'd0) begin errors++; $display("FAIL rst_out_max: got %0d required 0", out_max); end
      checks++; if (out_min !== 3'd0) begin errors++; $display("FAIL rst_out_min: got %0d required 0", out_min); end
      checks++; if (out_newmax !== 3'd0) begin errors++; $display("FAIL rst_out_newmax: got %0d required 0", out_newmax); end
`ifdef RANGE_TRACKER_SPREAD_EN
      checks++; if (out_spread !== 3'd0) begin errors++; $display("FAIL rst_out_spread: got %0d required 0", out_spread); end
`endif
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_mixed();
      stim[0] = 3; stim[1] = 7; stim[2] = 1; stim[3] = 5;
      out_ready = 1'b1;
      ref_model(4);
      send_samples(4, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mixed_latency: out_valid=%b required 1", out_valid); end
      checks++; if (out_max !== 3'd7 || out_max !== WIDTH'(exp_max)) begin errors++; $display("FAIL mixed_max: got %0d required 7", out_max); end
      checks++; if (out_min !== 3'd1 || out_min !== WIDTH'(exp_min)) begin errors++; $display("FAIL mixed_min: got %0d required 1", out_min); end
      checks++; if (out_newmax !== 3'd1 || out_newmax !== CW'(exp_nm)) begin errors++; $display("FAIL mixed_newmax: got %0d required 1", out_newmax); end
`ifdef RANGE_TRACKER_SPREAD_EN
      checks++; if (out_spread !== 3'd6) begin errors++; $display("FAIL mixed_spread: got %0d required 6", out_spread); end
`endif
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mixed_after_take: out_valid=%b required 0", out_valid); end
      checks++; if (out_max !== 3'd7) begin errors++; $display("FAIL mixed_hold_max: got %0d required 7", out_max); end
   endtask

   task automatic test_all_equal();
      for (int i = 0; i < 4; i++) stim[i] = 5;
      out_ready = 1'b1;
      send_samples(4, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL equal_valid: got %b required 1", out_valid); end
      checks++; if (out_max !== 3'd5 || out_min !== 3'd5) begin errors++; $display("FAIL equal_maxmin: got %0d/%0d required 5/5", out_max, out_min); end
      checks++; if (out_newmax !== 3'd0) begin errors++; $display("FAIL equal_newmax: got %0d required 0", out_newmax); end
`ifdef RANGE_TRACKER_SPREAD_EN
      checks++; if (out_spread !== 3'd0) begin errors++; $display("FAIL equal_spread: got %0d required 0", out_spread); end
`endif
      @(negedge clk);
   endtask

   task automatic test_ascending_gaps();
      stim[0] = 0; stim[1] = 2; stim[2] = 4; stim[3] = 7;
      out_ready = 1'b1;
      send_samples(3, 1);
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_no_early_valid: got %b required 0", out_valid); end
      stim[0] = 7;
      send_samples(1, 1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %b required 1", out_valid); end
      checks++; if (out_max !== 3'd7 || out_min !== 3'd0) begin errors++; $display("FAIL gaps_maxmin: got %0d/%0d required 7/0", out_max, out_min); end
      checks++; if (out_newmax !== 3'd3) begin errors++; $display("FAIL gaps_newmax: got %0d required 3", out_newmax); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      stim[0] = 1; stim[1] = 4; stim[2] = 3; stim[3] = 0;
      ref_model(4);
      out_ready = 1'b0;
      send_samples(4, 0);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = 3'd6;
         #1;
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake c%0d: valid=%b ready=%b required 1/0", c, out_valid, in_ready); end
         checks++; if (out_max !== WIDTH'(exp_max) || out_min !== WIDTH'(exp_min) || out_newmax !== CW'(exp_nm)) begin
            errors++; $display("FAIL bp_stable c%0d: got %0d/%0d/%0d required %0d/%0d/%0d", c, out_max, out_min, out_newmax, exp_max, exp_min, exp_nm);
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: out_valid=%b required 0", out_valid); end
      for (int i = 0; i < 4; i++) stim[i] = 2;
      send_samples(4, 0);
      checks++; if (out_max !== 3'd2 || out_min !== 3'd2 || out_newmax !== 3'd0) begin errors++; $display("FAIL bp_next_window: got %0d/%0d/%0d required 2/2/0", out_max, out_min, out_newmax); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      stim[0] = 7; stim[1] = 0;
      out_ready = 1'b1;
      send_samples(2, 0);
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_during: valid=%b ready=%b required 0/0", out_valid, in_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after: out_valid=%b required 0", out_valid); end
      stim[0] = 4; stim[1] = 5; stim[2] = 6; stim[3] = 3;
      send_samples(3, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_restart: out_valid=%b required 0", out_valid); end
      stim[0] = 3;
      send_samples(1, 0);
      checks++; if (out_max !== 3'd6 || out_min !== 3'd3 || out_newmax !== 3'd2) begin errors++; $display("FAIL midrst_result: got %0d/%0d/%0d required 6/3/2", out_max, out_min, out_newmax); end
      @(negedge clk);
   endtask

   task automatic test_boundary();
      stim[0] = 7; stim[1] = 7; stim[2] = 0; stim[3] = 0;
      out_ready = 1'b0;
      send_samples(4, 0);
      checks++; if (out_max !== 3'd7 || out_min !== 3'd0 || out_newmax !== 3'd0) begin errors++; $display("FAIL bound_result: got %0d/%0d/%0d required 7/0/0", out_max, out_min, out_newmax); end
`ifdef RANGE_TRACKER_SPREAD_EN
      checks++; if (out_spread !== 3'd7) begin errors++; $display("FAIL bound_spread: got %0d required 7", out_spread); end
`endif
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bound_idle_after_take: valid=%b ready=%b required 0/1", out_valid, in_ready); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int wait_c;
      for (int w = 0; w < 30; w++) begin
         for (int i = 0; i < 4; i++) stim[i] = int'($urandom_range(0, 7));
         ref_model(4);
         out_ready = 1'b0;
         send_samples(4, int'($urandom_range(0, 2)));
         wait_c = int'($urandom_range(0, 3));
         repeat (wait_c) @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rand_valid w%0d: got %b required 1", w, out_valid); end
         checks++; if (out_max !== WIDTH'(exp_max) || out_min !== WIDTH'(exp_min) || out_newmax !== CW'(exp_nm)) begin
            errors++; $display("FAIL rand_result w%0d: got %0d/%0d/%0d required %0d/%0d/%0d", w, out_max, out_min, out_newmax, exp_max, exp_min, exp_nm);
         end
`ifdef RANGE_TRACKER_SPREAD_EN
         checks++; if (out_spread !== WIDTH'(exp_max - exp_min)) begin errors++; $display("FAIL rand_spread w%0d: got %0d required %0d", w, out_spread, exp_max - exp_min); end
`endif
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_mixed();
      test_all_equal();
      test_ascending_gaps();
      test_backpressure();
      test_reset_mid();
      test_boundary();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
